// File: rtl/data_mem_adapter.sv
// data_mem_adapter: byte/half/word load-store adapter in front of a word-wide
// single-port memory, with alignment checking and read-modify-write sub-word stores.
`default_nettype none

module data_mem_adapter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_ReqValid,
  output logic                  o_ReqReady,
  input  logic                  i_ReqWrite,
  input  logic [ADDR_WIDTH+1:0] i_ReqAddr,
  input  logic [1:0]            i_ReqSize,
  input  logic                  i_ReqUnsigned,
  input  logic [31:0]           i_ReqWrData,
  output logic                  o_RspValid,
  input  logic                  i_RspReady,
  output logic [31:0]           o_RspRdData,
  output logic                  o_RspError,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  output logic                  o_MemWrEnable,
  output logic [31:0]           o_MemWrData,
  input  logic [31:0]           i_MemRdData
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [ADDR_WIDTH+1:0] lat_addr;
  logic [1:0]            lat_size;
  logic                  lat_unsigned;
  logic [31:0]           lat_wdata;
  logic [31:0]           rsp_rd_data;
  logic                  rsp_error;
  logic [31:0]           mem_wr_data;

  logic                  accept;
  logic                  req_error;
  logic [4:0]            lane_shift;
  logic [31:0]           lane_data;
  logic [31:0]           load_ext;
  logic [31:0]           merge_mask;
  logic [31:0]           merge_data;
  logic [31:0]           merged_word;

  assign accept = i_ReqValid && o_ReqReady;

  // Misalignment and the reserved size are detected before anything is latched.
  assign req_error = (i_ReqSize == 2'b11) ||
                     ((i_ReqSize == SZ_HALF) && i_ReqAddr[0]) ||
                     ((i_ReqSize == SZ_WORD) && (i_ReqAddr[1:0] != 2'b00));

  // Byte lanes shift by 8*addr[1:0]; halfwords use addr[0]==0 so the same shift works.
  assign lane_shift = {lat_addr[1:0], 3'b000};
  assign lane_data  = i_MemRdData >> lane_shift;

  always_comb begin
    load_ext   = i_MemRdData;
    merge_mask = 32'hFFFF_FFFF;
    merge_data = lat_wdata;
    case (lat_size)
      SZ_BYTE: begin
        load_ext   = lat_unsigned ? {24'd0, lane_data[7:0]}
                                  : {{24{lane_data[7]}}, lane_data[7:0]};
        merge_mask = 32'h0000_00FF << lane_shift;
        merge_data = {24'd0, lat_wdata[7:0]} << lane_shift;
      end
      SZ_HALF: begin
        load_ext   = lat_unsigned ? {16'd0, lane_data[15:0]}
                                  : {{16{lane_data[15]}}, lane_data[15:0]};
        merge_mask = 32'h0000_FFFF << lane_shift;
        merge_data = {16'd0, lat_wdata[15:0]} << lane_shift;
      end
      default: begin
        load_ext   = i_MemRdData;
        merge_mask = 32'hFFFF_FFFF;
        merge_data = lat_wdata;
      end
    endcase
  end

  assign merged_word = (i_MemRdData & ~merge_mask) | (merge_data & merge_mask);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_error) begin
            next_state = S_RESP;
          end else if (!i_ReqWrite) begin
            next_state = S_READ;
          end else if (i_ReqSize == SZ_WORD) begin
            next_state = S_WRITE;
          end else begin
            next_state = S_MERGE;
          end
        end
      end
      S_READ:  next_state = S_RESP;
      S_MERGE: next_state = S_WRITE;
      S_WRITE: next_state = S_RESP;
      S_RESP:  if (i_RspReady) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_ReqReady    = (state == S_IDLE) && !i_Reset;
    o_RspValid    = (state == S_RESP);
    o_MemWrEnable = (state == S_WRITE) && !i_Reset;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      lat_addr     <= '0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_wdata    <= 32'd0;
      rsp_rd_data  <= 32'd0;
      rsp_error    <= 1'b0;
      mem_wr_data  <= 32'd0;
    end else begin
      if (accept) begin
        lat_addr     <= i_ReqAddr;
        lat_size     <= i_ReqSize;
        lat_unsigned <= i_ReqUnsigned;
        lat_wdata    <= i_ReqWrData;
        rsp_rd_data  <= 32'd0;
        rsp_error    <= req_error;
        if (i_ReqWrite && (i_ReqSize == SZ_WORD)) begin
          mem_wr_data <= i_ReqWrData;
        end
      end
      if (state == S_READ) begin
        rsp_rd_data <= load_ext;
      end
      if (state == S_MERGE) begin
        mem_wr_data <= merged_word;
      end
    end
  end

  assign o_MemAddr   = lat_addr[ADDR_WIDTH+1:2];
  assign o_MemWrData = mem_wr_data;
  assign o_RspRdData = rsp_rd_data;
  assign o_RspError  = rsp_error;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_adapter.sv
// Scoreboard bench for data_mem_adapter: directed requests push expected
// responses; a negedge monitor pops and compares them against the DUT.
`default_nettype none

module tb_data_mem_adapter;

  localparam int AW = 12;

  logic          clk;
  logic          i_Reset;
  logic          i_ReqValid;
  logic          o_ReqReady;
  logic          i_ReqWrite;
  logic [AW+1:0] i_ReqAddr;
  logic [1:0]    i_ReqSize;
  logic          i_ReqUnsigned;
  logic [31:0]   i_ReqWrData;
  logic          o_RspValid;
  logic          i_RspReady;
  logic [31:0]   o_RspRdData;
  logic          o_RspError;
  logic [AW-1:0] o_MemAddr;
  logic          o_MemWrEnable;
  logic [31:0]   o_MemWrData;
  logic [31:0]   i_MemRdData;

  data_mem_adapter #(.ADDR_WIDTH(AW)) dut (
    .i_Clock      (clk),
    .i_Reset      (i_Reset),
    .i_ReqValid   (i_ReqValid),
    .o_ReqReady   (o_ReqReady),
    .i_ReqWrite   (i_ReqWrite),
    .i_ReqAddr    (i_ReqAddr),
    .i_ReqSize    (i_ReqSize),
    .i_ReqUnsigned(i_ReqUnsigned),
    .i_ReqWrData  (i_ReqWrData),
    .o_RspValid   (o_RspValid),
    .i_RspReady   (i_RspReady),
    .o_RspRdData  (o_RspRdData),
    .o_RspError   (o_RspError),
    .o_MemAddr    (o_MemAddr),
    .o_MemWrEnable(o_MemWrEnable),
    .o_MemWrData  (o_MemWrData),
    .i_MemRdData  (i_MemRdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write on the rising edge.
  logic [31:0] mem [0:(1<<AW)-1];
  initial for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
  always @(posedge clk) if (o_MemWrEnable) mem[o_MemAddr] <= o_MemWrData;
  assign i_MemRdData = mem[o_MemAddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 0;
  int   total = 0;
  int   bad = 0;
  int   last_accept = 0;
  int   wr_count = 0;
  int   wr_lat = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: response checking and write observation, decoupled from stimulus.
  always @(negedge clk) begin
    if (o_MemWrEnable) begin
      wr_count++;
      wr_addr = o_MemAddr;
      wr_data = o_MemWrData;
      wr_lat  = cyc - last_accept;
    end
    if (o_RspValid) begin
      if (!have_cur) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          chk("rsp_latency", 32'(cyc - cur.acc), 32'(cur.lat));
        end
      end
      if (have_cur) begin
        chk("rsp_rd", o_RspRdData, cur.rd);
        chk("rsp_err", {31'd0, o_RspError}, {31'd0, cur.err});
        if (i_RspReady) have_cur = 0;
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW+1:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input bit push);
    bit ok = 0;
    exp_t e;
    @(negedge clk);
    i_ReqValid = 1'b1;
    i_ReqWrite = wr;
    i_ReqAddr = addr;
    i_ReqSize = size;
    i_ReqUnsigned = uns;
    i_ReqWrData = wd;
    for (int k = 0; k < 50; k++) begin
      if (o_ReqReady) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      i_ReqValid = 1'b0;
      return;
    end
    last_accept = cyc;
    if (push) begin
      e.rd = exp_rd;
      e.err = exp_err;
      e.lat = exp_lat;
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 i_ReqValid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !have_cur && o_ReqReady) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  int wc;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=hang want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Reset = 1'b1;
    i_ReqValid = 1'b0;
    i_ReqWrite = 1'b0;
    i_ReqAddr = '0;
    i_ReqSize = 2'b00;
    i_ReqUnsigned = 1'b0;
    i_ReqWrData = 32'd0;
    i_RspReady = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", {31'd0, o_ReqReady}, 32'd0);
    chk("reset_rsp_valid", {31'd0, o_RspValid}, 32'd0);
    chk("reset_rd", o_RspRdData, 32'd0);
    chk("reset_err", {31'd0, o_RspError}, 32'd0);
    chk("reset_mem_addr", 32'(o_MemAddr), 32'd0);
    chk("reset_mem_we", {31'd0, o_MemWrEnable}, 32'd0);
    chk("reset_mem_wd", o_MemWrData, 32'd0);
    i_Reset = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", {31'd0, o_ReqReady}, 32'd1);

    // Word store, then loads of each lane/size from the same word.
    wc = wr_count;
    issue(1, 14'h010, 2'b10, 0, 32'hDEADBEEF, 32'd0, 0, 2, 1);
    wait_done();
    chk("wstore_wr_count", 32'(wr_count), 32'(wc + 1));
    chk("wstore_wr_addr", 32'(wr_addr), 32'h4);
    chk("wstore_wr_data", wr_data, 32'hDEADBEEF);
    chk("wstore_wr_lat", 32'(wr_lat), 32'd1);
    chk("wstore_mem", mem[4], 32'hDEADBEEF);

    issue(0, 14'h013, 2'b00, 1, 32'd0, 32'h000000DE, 0, 2, 1);
    issue(0, 14'h012, 2'b00, 0, 32'd0, 32'hFFFFFFAD, 0, 2, 1);
    issue(0, 14'h012, 2'b01, 0, 32'd0, 32'hFFFFDEAD, 0, 2, 1);
    issue(0, 14'h010, 2'b01, 1, 32'd0, 32'h0000BEEF, 0, 2, 1);
    issue(0, 14'h011, 2'b00, 0, 32'd0, 32'hFFFFFFBE, 0, 2, 1);
    issue(0, 14'h010, 2'b10, 0, 32'd0, 32'hDEADBEEF, 0, 2, 1);
    wait_done();

    // Byte store merges into the existing word.
    wc = wr_count;
    issue(1, 14'h011, 2'b00, 0, 32'hAAAAAA55, 32'd0, 0, 3, 1);
    wait_done();
    chk("bstore_wr_count", 32'(wr_count), 32'(wc + 1));
    chk("bstore_wr_lat", 32'(wr_lat), 32'd2);
    chk("bstore_mem", mem[4], 32'hDEAD55EF);
    issue(0, 14'h010, 2'b10, 0, 32'd0, 32'hDEAD55EF, 0, 2, 1);

    // Half store into the upper half of another word, top address wraps to last word.
    issue(1, 14'h3FFE, 2'b01, 0, 32'h0000CAFE, 32'd0, 0, 3, 1);
    wait_done();
    chk("hstore_top_mem", mem[(1 << AW) - 1], 32'hCAFE0000);

    // Error requests: no memory writes.
    wc = wr_count;
    issue(1, 14'h012, 2'b10, 0, 32'h12345678, 32'd0, 1, 1, 1);
    issue(0, 14'h011, 2'b01, 0, 32'd0, 32'd0, 1, 1, 1);
    issue(1, 14'h010, 2'b11, 0, 32'h0000FFFF, 32'd0, 1, 1, 1);
    wait_done();
    chk("err_no_write", 32'(wr_count), 32'(wc));
    chk("err_mem_intact", mem[4], 32'hDEAD55EF);

    // Back-pressure: response must hold while i_RspReady is low.
    i_RspReady = 1'b0;
    issue(0, 14'h010, 2'b01, 1, 32'd0, 32'h000055EF, 0, 2, 1);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_req_ready", {31'd0, o_ReqReady}, 32'd0);
      chk("hold_rsp_valid", {31'd0, o_RspValid}, 32'd1);
    end
    @(posedge clk);
    #1 i_RspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("release_req_ready", {31'd0, o_ReqReady}, 32'd1);
    chk("release_rsp_valid", {31'd0, o_RspValid}, 32'd0);

    // Reset during the WRITE of a half store suppresses the write.
    wc = wr_count;
    issue(1, 14'h010, 2'b01, 0, 32'h00001234, 32'd0, 0, 3, 0);
    @(posedge clk);
    #1 i_Reset = 1'b1;
    @(negedge clk);
    chk("rst_we_suppressed", {31'd0, o_MemWrEnable}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'd0, o_RspValid}, 32'd0);
    chk("rst_rd", o_RspRdData, 32'd0);
    chk("rst_err", {31'd0, o_RspError}, 32'd0);
    chk("rst_mem_addr", 32'(o_MemAddr), 32'd0);
    chk("rst_mem_wd", o_MemWrData, 32'd0);
    chk("rst_req_ready", {31'd0, o_ReqReady}, 32'd0);
    i_Reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", {31'd0, o_ReqReady}, 32'd1);
    chk("rst_no_write", 32'(wr_count), 32'(wc));
    chk("rst_mem_intact", mem[4], 32'hDEAD55EF);
    issue(0, 14'h010, 2'b10, 0, 32'd0, 32'hDEAD55EF, 0, 2, 1);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/data_mem_adapter.md
# data_mem_adapter

Load/store adapter between the core's data-access port and the word-wide, single-port data `Memory`. That memory has combinational read, a synchronous write on the clock edge, and no byte enables. This block accepts byte, halfword and word requests on byte addresses, and checks alignment. It does read-modify-write for sub-word stores and sign/zero-extends load data. One request is in flight at a time, under a valid/ready handshake on both sides.

## Interface
Parameters:
- ADDR_WIDTH, 12: word-address width of the attached memory; byte address is ADDR_WIDTH+2 bits. Data path is fixed at 32 bits.

Ports:
- i_Clock  in  1  clock; all state changes on the rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_ReqValid  in  1  request present
- o_ReqReady  out  1  block can accept a request
- i_ReqWrite  in  1  1 = store, 0 = load
- i_ReqAddr  in  ADDR_WIDTH+2  byte address
- i_ReqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
- i_ReqUnsigned  in  1  load zero-extends when 1, else sign-extends
- i_ReqWrData  in  32  store data, right-aligned (low bits used)
- o_RspValid  out  1  response present
- i_RspReady  in  1  consumer takes response
- o_RspRdData  out  32  extended load data; 0 for stores and errors
- o_RspError  out  1  misaligned or illegal-size request; no memory write performed
- o_MemAddr  out  ADDR_WIDTH  word address to memory (latched byte address >> 2)
- o_MemWrEnable  out  1  memory write strobe
- o_MemWrData  out  32  full word to write
- i_MemRdData  in  32  memory read data (combinational from o_MemAddr)

## Operation
- FSM states: IDLE, READ, MERGE, WRITE, RESP.
- o_ReqReady = (state == IDLE) && !i_Reset. Acceptance = i_ReqValid && o_ReqReady. All request fields latched on acceptance.
- Error check at acceptance. Error = size 11, half with addr[0]=1, or word with addr[1:0]≠00. On error: IDLE→RESP with o_RspError=1 and o_RspRdData=0. The memory is not touched.
- Load: IDLE→READ→RESP. In READ, lane = addr[1:0] is extracted from i_MemRdData: byte = bits 8·lane+7..8·lane; half = bits 16·addr[1]+15.. Data is extended per i_ReqUnsigned and registered into o_RspRdData.
- Word store: IDLE→WRITE→RESP. o_MemWrData = latched data.
- Sub-word store: IDLE→MERGE→WRITE→RESP.
  - In MERGE, i_MemRdData is registered with the selected lane(s) replaced by the low 8/16 bits of the store data.
  - In WRITE, that merged word is written.
- o_MemWrEnable = (state == WRITE) && !i_Reset; it is high for exactly one cycle per store.
- o_MemAddr holds the latched word address from acceptance until the next acceptance.
- RESP: o_RspValid=1, with o_RspRdData and o_RspError stable, until i_RspReady. RESP→IDLE on the cycle where i_RspReady=1.
- Stores answer with o_RspRdData=0, o_RspError=0.

## Timing
- Reset values: state IDLE, o_RspValid 0, o_RspRdData 0, o_RspError 0, o_MemAddr 0, o_MemWrData 0, o_MemWrEnable 0. o_ReqReady is 0 while i_Reset=1 and 1 in the first cycle after.
- Accept at edge T. The earliest o_RspValid is:
  - error: cycle T+1
  - load: T+2
  - word store: T+2, with the write at the edge ending T+1
  - sub-word store: T+3, with the write at the edge ending T+2
- Throughput: at most one request per 3 cycles (load/word store) or 4 cycles (sub-word), with i_RspReady tied high.
- o_ReqReady is low from acceptance until the cycle after the response is taken. There is no overlap of a new request with a pending response.
- i_RspReady held low: RESP persists indefinitely and the outputs do not change.
- Reset mid-operation, including in WRITE: the write is suppressed that cycle. The next state is IDLE, any pending response is discarded, and memory contents are otherwise untouched.
- Address wrap: no special handling. The top byte address maps to word 2^ADDR_WIDTH−1.

## Test plan
- Word store 0xDEADBEEF @0x010, then byte load unsigned @0x013: o_MemWrEnable for 1 cycle with o_MemAddr=0x004. The load response at T+2 is 0x000000DE, error=0.
- Byte load signed @0x012 of the same word: 0xFFFFFFAD. Half load signed @0x012: 0xFFFFDEAD. Half load unsigned @0x010: 0x0000BEEF.
- Byte store 0x55 @0x011 over 0xDEADBEEF: MERGE then WRITE. The memory word becomes 0xDEAD55EF and the response arrives at T+3.
- Misaligned word store @0x012 and half load @0x011: o_RspError=1 at T+1, rd=0, and o_MemWrEnable never asserts.
- Hold i_RspReady=0 for 5 cycles after a load: o_RspValid and the data stay stable and o_ReqReady stays 0. The response is taken on the cycle i_RspReady=1, and o_ReqReady=1 the next cycle.
- Assert i_Reset during WRITE of a half store: no memory write occurs. All outputs are at their reset values the next cycle, and o_ReqReady=1 after reset drops.
